// File: rtl/f_norm_pipe.sv
// Purpose : two-stage mantissa normaliser (LZC, left shift, exponent adjust, denormal clamp).
// Latency : two register stages (input capture with LZC, then shift/adjust into the output regs).
// Backpres: valid/ready on both sides; in_ready is combinational from out_ready; holds 2 beats.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   in_valid/in_ready        input handshake; in_mant (MW), in_exp (EW, biased)
//   out_valid/out_ready      output handshake
//   out_mant, out_exp        normalised mantissa and adjusted exponent
//   out_lzc                  true leading-zero count (0..MW), even when the shift is clamped
//   out_zero, out_denorm     mantissa was zero / shift was clamped by the exponent
module f_norm_pipe #(
  parameter int MW = 23,
  parameter int EW = 8,
  parameter int LW = $clog2(MW + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_mant,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [EW-1:0] out_exp,
  output logic [LW-1:0] out_lzc,
  output logic          out_zero,
  output logic          out_denorm
);

  // Common width for comparing the count against the exponent without truncation.
  localparam int CW = ((LW > EW) ? LW : EW) + 1;

  logic          a_vld;
  logic [MW-1:0] a_mant;
  logic [EW-1:0] a_exp;
  logic [LW-1:0] a_lzc;
  logic          b_vld;
  logic          adv_a;
  logic          adv_b;
  logic [LW-1:0] lzc_in;
  logic [CW-1:0] lzc_x;
  logic [CW-1:0] exp_x;
  logic [MW-1:0] nx_mant;
  logic [EW-1:0] nx_exp;
  logic          nx_zero;
  logic          nx_denorm;

  assign adv_b     = !b_vld || out_ready;
  assign adv_a     = !a_vld || adv_b;
  assign in_ready  = adv_a;
  assign out_valid = b_vld;

  // Scan upward so the highest set bit writes last and wins; no set bit leaves MW.
  always_comb begin
    lzc_in = LW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (in_mant[i]) lzc_in = LW'(MW - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_vld  <= 1'b0;
      a_mant <= '0;
      a_exp  <= '0;
      a_lzc  <= '0;
    end else if (adv_a) begin
      a_vld <= in_valid;
      if (in_valid) begin
        a_mant <= in_mant;
        a_exp  <= in_exp;
        a_lzc  <= lzc_in;
      end
    end
  end

  assign lzc_x = CW'(a_lzc);
  assign exp_x = CW'(a_exp);

  // When the exponent cannot absorb the full shift, shift only by the exponent
  // so the result lands on exponent 0 instead of wrapping.
  always_comb begin
    nx_mant   = '0;
    nx_exp    = '0;
    nx_zero   = 1'b0;
    nx_denorm = 1'b0;
    if (a_lzc == LW'(MW)) begin
      nx_zero = 1'b1;
    end else if (lzc_x < exp_x) begin
      nx_mant = a_mant << a_lzc;
      nx_exp  = EW'(exp_x - lzc_x);
    end else begin
      nx_mant   = a_mant << a_exp;
      nx_denorm = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_vld      <= 1'b0;
      out_mant   <= '0;
      out_exp    <= '0;
      out_lzc    <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
    end else if (adv_b) begin
      b_vld <= a_vld;
      if (a_vld) begin
        out_mant   <= nx_mant;
        out_exp    <= nx_exp;
        out_lzc    <= a_lzc;
        out_zero   <= nx_zero;
        out_denorm <= nx_denorm;
      end
    end
  end

endmodule

// File: tb/tb_f_norm_pipe.sv
// Purpose : self-checking bench for f_norm_pipe with a queue scoreboard and stall/reset cases.
// Latency : expects output valid after the second rising edge counted from the accept edge.
// Backpres: drives out_ready low in windows and randomly; in_ready predicted from in-flight count.
module tb_f_norm_pipe;
  localparam int MW = 23;
  localparam int EW = 8;
  localparam int LW = $clog2(MW + 1);

  typedef struct packed {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic [LW-1:0] lzc;
    logic          zero;
    logic          denorm;
  } res_t;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [LW-1:0] out_lzc;
  logic          out_zero;
  logic          out_denorm;

  int   checks = 0;
  int   errors = 0;
  res_t sb_q[$];
  res_t prev_obs;
  bit   stalled = 0;
  bit   saw_full = 0;
  logic [MW-1:0] stim_m[32];
  logic [EW-1:0] stim_e[32];

  f_norm_pipe #(.MW(MW), .EW(EW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_lzc(out_lzc), .out_zero(out_zero), .out_denorm(out_denorm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [MW-1:0] m, input logic [EW-1:0] e);
    res_t r;
    int   lz;
    bit   found;
    r = '0;
    lz = MW;
    found = 0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found && m[i]) begin
        lz = MW - 1 - i;
        found = 1;
      end
    end
    r.lzc = LW'(lz);
    if (m == '0) begin
      r.zero = 1'b1;
    end else if (lz < int'(e)) begin
      r.mant = m << lz;
      r.exp  = EW'(int'(e) - lz);
    end else begin
      r.mant   = m << e;
      r.denorm = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard monitor: handshakes are stable between edges, so sample on the falling edge.
  always @(negedge clk) begin
    res_t obs;
    res_t exp_r;
    obs = {out_mant, out_exp, out_lzc, out_zero, out_denorm};
    if (!reset_n) begin
      sb_q.delete();
      stalled = 0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'((sb_q.size() < 2) || out_ready));
      if (!in_ready) saw_full = 1;
      if (stalled) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(obs), 64'(prev_obs));
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
          exp_r = sb_q.pop_front();
          chk("mant", 64'(out_mant), 64'(exp_r.mant));
          chk("exp", 64'(out_exp), 64'(exp_r.exp));
          chk("lzc", 64'(out_lzc), 64'(exp_r.lzc));
          chk("zero", 64'(out_zero), 64'(exp_r.zero));
          chk("denorm", 64'(out_denorm), 64'(exp_r.denorm));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_mant, in_exp));
      stalled  = out_valid && !out_ready;
      prev_obs = obs;
    end
  end

  // Single beat into an empty pipe; checks timing and the expected fields directly.
  task automatic lat_beat(input logic [MW-1:0] m, input logic [EW-1:0] e,
                          input logic [MW-1:0] xm, input logic [EW-1:0] xe,
                          input logic [LW-1:0] xl, input logic xz, input logic xd);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mant   = m;
    in_exp    = e;
    @(negedge clk);
    chk("lat_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_edge1_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_edge2_valid", 64'(out_valid), 64'(1));
    chk("vec_mant", 64'(out_mant), 64'(xm));
    chk("vec_exp", 64'(out_exp), 64'(xe));
    chk("vec_lzc", 64'(out_lzc), 64'(xl));
    chk("vec_zero", 64'(out_zero), 64'(xz));
    chk("vec_denorm", 64'(out_denorm), 64'(xd));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'(0));
  endtask

  // Streams n beats from stim_*; out_ready low for cycles st_lo..st_hi, or random when rnd.
  task automatic run_stream(input int n, input int st_lo, input int st_hi, input bit rnd);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 2000) begin
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else     out_ready = !(cyc >= st_lo && cyc <= st_hi);
      in_valid = 1'b1;
      in_mant  = stim_m[idx];
      in_exp   = stim_e[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    chk("stream_accepted", 64'(idx), 64'(n));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_mant", 64'(out_mant), 64'(0));
    chk("rst_exp", 64'(out_exp), 64'(0));
    chk("rst_lzc", 64'(out_lzc), 64'(0));
    chk("rst_zero", 64'(out_zero), 64'(0));
    chk("rst_denorm", 64'(out_denorm), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Directed vectors
    lat_beat(23'h400000, 8'd10,  23'h400000, 8'd10, 5'd0,  1'b0, 1'b0);
    lat_beat(23'h000001, 8'd100, 23'h400000, 8'd78, 5'd22, 1'b0, 1'b0);
    lat_beat(23'h000100, 8'd5,   23'h002000, 8'd0,  5'd14, 1'b0, 1'b1);
    lat_beat(23'h000000, 8'd77,  23'h000000, 8'd0,  5'd23, 1'b1, 1'b0);
    lat_beat(23'h000100, 8'd14,  23'h400000, 8'd0,  5'd14, 1'b0, 1'b1);
    lat_beat(23'h000100, 8'd15,  23'h400000, 8'd1,  5'd14, 1'b0, 1'b0);
    lat_beat(23'h012345, 8'd0,   23'h012345, 8'd0,  5'd6,  1'b0, 1'b1);
    drain();

    // Six beats with out_ready low for cycles 2..5
    for (int i = 0; i < 6; i++) begin
      stim_m[i] = MW'(32'h7FFFFF >> (i * 3)) ^ MW'(i);
      stim_e[i] = EW'(4 + i * 5);
    end
    saw_full = 0;
    run_stream(6, 2, 5, 1'b0);
    chk("stall_filled", 64'(saw_full), 64'(1));

    // Random stream with random backpressure
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) stim_m[i] = '0;
      else stim_m[i] = MW'($urandom() >> $urandom_range(9, 31));
      if ($urandom_range(0, 3) == 0) stim_e[i] = EW'($urandom_range(0, 255));
      else stim_e[i] = EW'($urandom_range(0, 25));
    end
    run_stream(30, 0, -1, 1'b1);

    // Reset with two beats held in the pipe
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mant   = 23'h000F00;
    in_exp    = 8'd50;
    @(posedge clk); #1;
    in_mant = 23'h000003;
    in_exp  = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_mant", 64'(out_mant), 64'(0));
    chk("mid_rst_lzc", 64'(out_lzc), 64'(0));
    @(negedge clk);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    lat_beat(23'h000010, 8'd30, 23'h400000, 8'd12, 5'd18, 1'b0, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("no_stale_valid", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
